// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one signed 32-bit comparator among NUM_REQ requesters.
// One registered compare stage; per-requester result registers hold responses until popped.

module comparator_32bit (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_eq,
  output logic        o_lt,
  output logic        o_gt
);
  assign o_eq = (i_a == i_b);
  assign o_lt = ($signed(i_a) < $signed(i_b));
  assign o_gt = !o_eq && !o_lt;
endmodule

module cmp_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int RR_INIT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]  req_op,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic [NUM_REQ-1:0]   rsp_taken,
  output logic [NUM_REQ*3-1:0] rsp_flags
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_CMP = 1'b1} state_t;

  state_t                    r_state;
  logic [IDW-1:0]            r_rr_ptr;
  logic [IDW-1:0]            r_id;
  logic [31:0]               r_a;
  logic [31:0]               r_b;
  logic [2:0]                r_op;
  logic [NUM_REQ-1:0]        r_rsp_valid;
  logic [NUM_REQ-1:0]        r_rsp_taken;
  logic [NUM_REQ-1:0][2:0]   r_rsp_flags;

  logic [31:0]        w_a_arr  [NUM_REQ];
  logic [31:0]        w_b_arr  [NUM_REQ];
  logic [2:0]         w_op_arr [NUM_REQ];
  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDW-1:0]     w_grant_id;
  logic [IDW-1:0]     w_rr_next;
  logic               w_found;
  int                 w_idx;
  logic               w_uns;
  logic [31:0]        w_cmp_a;
  logic [31:0]        w_cmp_b;
  logic               w_eq;
  logic               w_lt;
  logic               w_gt;
  logic               w_taken;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_a_arr[gi]  = req_a[32*gi +: 32];
      assign w_b_arr[gi]  = req_b[32*gi +: 32];
      assign w_op_arr[gi] = req_op[3*gi +: 3];
    end
  endgenerate

  // A requester still holding an unpopped result cannot be granted again.
  assign w_elig = req_valid & ~r_rsp_valid;

  always_comb begin
    w_grant    = '0;
    w_grant_id = '0;
    w_found    = 1'b0;
    w_idx      = 0;
    if (r_state == ST_IDLE) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
        if (!w_found && w_elig[w_idx]) begin
          w_found        = 1'b1;
          w_grant[w_idx] = 1'b1;
          w_grant_id     = IDW'(w_idx);
        end
      end
    end
  end

  assign w_rr_next = (w_grant_id == IDW'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;
  assign req_ready = w_grant & {NUM_REQ{rst_n}};

  // Flipping the sign bits maps unsigned order onto the signed comparator.
  assign w_uns   = (r_op == 3'b110) || (r_op == 3'b111) || (r_op == 3'b011);
  assign w_cmp_a = {r_a[31] ^ w_uns, r_a[30:0]};
  assign w_cmp_b = {r_b[31] ^ w_uns, r_b[30:0]};

  comparator_32bit u_cmp (
    .i_a  (w_cmp_a),
    .i_b  (w_cmp_b),
    .o_eq (w_eq),
    .o_lt (w_lt),
    .o_gt (w_gt)
  );

  always_comb begin
    w_taken = w_lt;
    case (r_op)
      3'b000:         w_taken = w_eq;
      3'b001:         w_taken = !w_eq;
      3'b101, 3'b111: w_taken = !w_lt;
      default:        w_taken = w_lt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= IDW'(RR_INIT);
      r_id        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_rsp_valid <= '0;
      r_rsp_taken <= '0;
      r_rsp_flags <= '0;
    end else begin
      r_rsp_valid <= r_rsp_valid & ~rsp_ready;
      case (r_state)
        ST_IDLE: begin
          if (|w_grant) begin
            r_state  <= ST_CMP;
            r_a      <= w_a_arr[w_grant_id];
            r_b      <= w_b_arr[w_grant_id];
            r_op     <= w_op_arr[w_grant_id];
            r_id     <= w_grant_id;
            r_rr_ptr <= w_rr_next;
          end
        end
        ST_CMP: begin
          r_state              <= ST_IDLE;
          r_rsp_valid[r_id]    <= 1'b1;
          r_rsp_taken[r_id]    <= w_taken;
          r_rsp_flags[r_id]    <= {w_eq, w_lt, w_gt};
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_taken = r_rsp_taken;
  assign rsp_flags = r_rsp_flags;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed and randomized checks of cmp_share_arbiter with two requesters.
// Expected values are hand-derived or come from a $signed/$unsigned reference model.

module tb_cmp_share_arbiter;
  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [5:0]  req_op;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [1:0]  rsp_taken;
  logic [5:0]  rsp_flags;

  int checks = 0;
  int errors = 0;

  logic [3:0] q0[$];
  logic [3:0] q1[$];

  cmp_share_arbiter #(.NUM_REQ(2), .RR_INIT(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_taken (rsp_taken),
    .rsp_flags (rsp_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Returns {taken, eq, lt, gt}.
  function automatic logic [3:0] ref_cmp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic uns, eq, lt, gt, t;
    uns = (op == 3'b110) || (op == 3'b111) || (op == 3'b011);
    eq  = (a == b);
    lt  = uns ? (a < b) : ($signed(a) < $signed(b));
    gt  = !eq && !lt;
    case (op)
      3'b000:         t = eq;
      3'b001:         t = !eq;
      3'b101, 3'b111: t = !lt;
      default:        t = lt;
    endcase
    return {t, eq, lt, gt};
  endfunction

  task automatic single(input int id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic exp_t, input logic [2:0] exp_f, input string tag);
    logic [1:0] oh;
    oh               = '0;
    oh[id]           = 1'b1;
    req_valid        = oh;
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    req_op[3*id +: 3]  = op;
    rsp_ready        = '0;
    #1;
    chk($sformatf("%s_ready", tag), req_ready, oh);
    tick();
    req_valid = '0;
    #1;
    chk($sformatf("%s_busy", tag), req_ready, 2'b00);
    chk($sformatf("%s_latency", tag), rsp_valid, 2'b00);
    tick();
    chk($sformatf("%s_valid", tag), rsp_valid, oh);
    chk($sformatf("%s_taken", tag), rsp_taken[id], exp_t);
    chk($sformatf("%s_flags", tag), rsp_flags[3*id +: 3], exp_f);
    rsp_ready = oh;
    tick();
    rsp_ready = '0;
    chk($sformatf("%s_popped", tag), rsp_valid, 2'b00);
    chk($sformatf("%s_flags_kept", tag), rsp_flags[3*id +: 3], exp_f);
  endtask

  task automatic sb_eval();
    logic [3:0] e;
    for (int i = 0; i < 2; i++) begin
      if (rsp_valid[i] && rsp_ready[i]) begin
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
          chk($sformatf("t6_spurious_rsp%0d", i), rsp_valid[i], 1'b0);
        end else begin
          if (i == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk($sformatf("t6_taken%0d", i), rsp_taken[i], e[3]);
          chk($sformatf("t6_flags%0d", i), rsp_flags[3*i +: 3], e[2:0]);
          chk($sformatf("t6_onehot%0d", i), $countones(rsp_flags[3*i +: 3]), 1);
        end
      end
      if (req_valid[i] && req_ready[i]) begin
        e = ref_cmp(req_a[32*i +: 32], req_b[32*i +: 32], req_op[3*i +: 3]);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    #3;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_taken", rsp_taken, 2'b00);
    chk("rst_rsp_flags", rsp_flags, 6'b0);
    do_reset();

    // T1 / T2: single requests, signed and unsigned views
    single(0, 32'd5,        32'd5,        3'b000, 1'b1, 3'b100, "t1_beq");
    single(0, 32'hFFFFFFFF, 32'd1,        3'b100, 1'b1, 3'b010, "t2_blt");
    single(0, 32'hFFFFFFFF, 32'd1,        3'b110, 1'b0, 3'b001, "t2_bltu");
    single(0, 32'd5,        32'd5,        3'b001, 1'b0, 3'b100, "t2_bne_eq");
    single(1, 32'd3,        32'hFFFFFFFE, 3'b101, 1'b1, 3'b001, "t2_bge");
    single(1, 32'd1,        32'd2,        3'b111, 1'b0, 3'b010, "t2_bgeu");
    single(0, 32'h80000000, 32'h7FFFFFFF, 3'b011, 1'b0, 3'b001, "t2_sltu");
    single(1, 32'h80000000, 32'h7FFFFFFF, 3'b010, 1'b1, 3'b010, "t2_slt");
    single(1, 32'd7,        32'd8,        3'b000, 1'b0, 3'b010, "t2_beq_ne");

    // T3: round robin with both requesters always valid
    do_reset();
    req_a     = {32'd9, 32'd9};
    req_b     = {32'd1, 32'd1};
    req_op    = {3'b000, 3'b000};
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    #1;
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("t3_grant%0d", g), req_ready, (g % 2 == 1) ? 2'b10 : 2'b01);
      if (g > 0) chk($sformatf("t3_rsp%0d", g), rsp_valid, (g % 2 == 1) ? 2'b01 : 2'b10);
      tick();
      chk($sformatf("t3_cmp%0d", g), req_ready, 2'b00);
      tick();
    end
    req_valid = '0;
    tick();
    tick();
    chk("t3_drained", rsp_valid, 2'b00);

    // T4: unpopped result blocks its requester only
    do_reset();
    rsp_ready  = 2'b00;
    req_valid  = 2'b01;
    req_a[31:0] = 32'd1;
    req_b[31:0] = 32'd2;
    req_op[2:0] = 3'b100;
    #1;
    chk("t4_grant0", req_ready, 2'b01);
    tick();
    tick();
    req_valid    = 2'b11;
    req_a[63:32] = 32'd10;
    req_b[63:32] = 32'd10;
    req_op[5:3]  = 3'b001;
    #1;
    chk("t4_only1", req_ready, 2'b10);
    chk("t4_rsp0_held", rsp_valid, 2'b01);
    tick();
    chk("t4_rsp0_stable_v", rsp_valid, 2'b01);
    chk("t4_rsp0_stable_t", rsp_taken[0], 1'b1);
    chk("t4_rsp0_stable_f", rsp_flags[2:0], 3'b010);
    tick();
    chk("t4_both_held", rsp_valid, 2'b11);
    chk("t4_none_eligible", req_ready, 2'b00);
    chk("t4_rsp1_taken", rsp_taken[1], 1'b0);
    chk("t4_rsp1_flags", rsp_flags[5:3], 3'b100);
    rsp_ready = 2'b01;
    #1;
    chk("t4_pop_no_bypass", req_ready, 2'b00);
    tick();
    rsp_ready = 2'b00;
    #1;
    chk("t4_after_pop_v", rsp_valid, 2'b10);
    chk("t4_regrant0", req_ready, 2'b01);
    chk("t4_flags0_kept", rsp_flags[2:0], 3'b010);
    tick();
    tick();
    chk("t4_rsp0_again", rsp_valid, 2'b11);
    rsp_ready = 2'b11;
    req_valid = 2'b00;
    tick();
    rsp_ready = 2'b00;
    chk("t4_drained", rsp_valid, 2'b00);

    // T5: asynchronous reset during a compare for requester 1
    do_reset();
    req_valid    = 2'b10;
    req_a[63:32] = 32'd3;
    req_b[63:32] = 32'd4;
    req_op[5:3]  = 3'b100;
    #1;
    chk("t5_grant1", req_ready, 2'b10);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", rsp_valid, 2'b00);
    chk("t5_async_taken", rsp_taken, 2'b00);
    chk("t5_async_flags", rsp_flags, 6'b0);
    req_valid = 2'b11;
    #1;
    chk("t5_ready_in_rst", req_ready, 2'b00);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("t5_first_grant", req_ready, 2'b01);
    chk("t5_no_stale_rsp", rsp_valid, 2'b00);
    tick();
    req_valid = 2'b00;
    #1;
    chk("t5_no_rsp1", rsp_valid, 2'b00);
    tick();
    chk("t5_rsp0_only", rsp_valid, 2'b01);
    rsp_ready = 2'b11;
    tick();
    rsp_ready = 2'b00;

    // T6: random traffic against the reference model
    do_reset();
    q0.delete();
    q1.delete();
    for (int c = 0; c < 600; c++) begin
      rsp_ready = 2'($urandom_range(0, 3));
      for (int i = 0; i < 2; i++) begin
        logic [31:0] ra;
        logic [31:0] rb;
        ra = $urandom;
        case ($urandom_range(0, 3))
          0:       rb = ra;
          1:       rb = ra ^ 32'h80000000;
          default: rb = $urandom;
        endcase
        req_valid[i]       = ($urandom_range(0, 3) != 0);
        req_a[32*i +: 32]  = ra;
        req_b[32*i +: 32]  = rb;
        req_op[3*i +: 3]   = 3'($urandom_range(0, 7));
      end
      #1;
      sb_eval();
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    for (int c = 0; c < 6; c++) begin
      #1;
      sb_eval();
      tick();
    end
    chk("t6_q0_empty", q0.size(), 0);
    chk("t6_q1_empty", q1.size(), 0);
    chk("t6_final_valid", rsp_valid, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
